// File: rtl/cross_bar_req_arb.sv
// Round-robin request arbiter merging mcash channels 0-2 into the xbar->htu request stream.
// Optional performance counters are enabled by defining XBAR_ARB_PERF_EN.
module cross_bar_req_arb #(
    parameter int unsigned SET_LSB = 4,
    parameter int unsigned SET_W   = 3,
    parameter int unsigned RR_INIT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mcash_ch0_req_valid_i,
    output logic              mcash_ch0_req_allowIn_o,
    input  logic [2:0]        mcash_ch0_req_op_i,
    input  logic [27:0]       mcash_ch0_req_addr_i,
    input  logic              mcash_ch1_req_valid_i,
    output logic              mcash_ch1_req_allowIn_o,
    input  logic [2:0]        mcash_ch1_req_op_i,
    input  logic [27:0]       mcash_ch1_req_addr_i,
    input  logic              mcash_ch2_req_valid_i,
    output logic              mcash_ch2_req_allowIn_o,
    input  logic [2:0]        mcash_ch2_req_op_i,
    input  logic [27:0]       mcash_ch2_req_addr_i,
    output logic              xbar_htu_valid_o,
    input  logic              xbar_htu_ready_i,
    output logic [1:0]        xbar_htu_ch_id_o,
    output logic [1:0]        xbar_htu_opcode_o,
    output logic [31:0]       xbar_htu_addr_o,
    output logic [SET_W-1:0]  xbar_htu_set_o
`ifdef XBAR_ARB_PERF_EN
    ,
    output logic [15:0]       perf_grant_cnt_ch0_o,
    output logic [15:0]       perf_grant_cnt_ch1_o,
    output logic [15:0]       perf_grant_cnt_ch2_o,
    output logic [15:0]       perf_stall_cnt_o
`endif
);

    localparam int unsigned NCH   = 3;
    localparam int unsigned CH_W  = 2;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned LA_W  = 28;
    localparam int unsigned AD_W  = 32;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [LA_W-1:0] addr;
    } req_t;

    req_t             in_req_c [NCH];
    logic [NCH-1:0]   in_vld_c;

    req_t             buf_q [NCH];
    logic [NCH-1:0]   buf_vld_q;
    logic [CH_W-1:0]  rr_q;

    logic             out_vld_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [OP_W-1:0]  out_op_q;
    logic [AD_W-1:0]  out_addr_q;
    logic [SET_W-1:0] out_set_q;

    logic             out_load_c;
    logic             gnt_vld_c;
    logic [CH_W-1:0]  gnt_idx_c;
    logic [NCH-1:0]   grant_c;
    logic [NCH-1:0]   allow_c;
    logic [NCH-1:0]   accept_c;
    logic [AD_W-1:0]  ld_addr_c;

    // op[2] is defined as don't-care by the channel interface
    logic unused_op_msb;
    assign unused_op_msb = ^{mcash_ch0_req_op_i[2], mcash_ch1_req_op_i[2], mcash_ch2_req_op_i[2]};

    assign in_vld_c    = {mcash_ch2_req_valid_i, mcash_ch1_req_valid_i, mcash_ch0_req_valid_i};
    assign in_req_c[0] = req_t'{op: mcash_ch0_req_op_i[OP_W-1:0], addr: mcash_ch0_req_addr_i};
    assign in_req_c[1] = req_t'{op: mcash_ch1_req_op_i[OP_W-1:0], addr: mcash_ch1_req_addr_i};
    assign in_req_c[2] = req_t'{op: mcash_ch2_req_op_i[OP_W-1:0], addr: mcash_ch2_req_addr_i};

    // Channel index k positions after base, modulo NCH
    function automatic logic [CH_W-1:0] rr_pos(input logic [CH_W-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NCH) s = s - NCH;
        return CH_W'(s);
    endfunction

    assign out_load_c = !out_vld_q || xbar_htu_ready_i;

    // First valid buffer in rotating order starting at rr_q
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        grant_c   = '0;
        if (out_load_c) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!gnt_vld_c && buf_vld_q[rr_pos(rr_q, k)]) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = rr_pos(rr_q, k);
                end
            end
        end
        if (gnt_vld_c) grant_c[gnt_idx_c] = 1'b1;
    end

    assign allow_c   = ~buf_vld_q | grant_c;
    assign accept_c  = in_vld_c & allow_c;
    assign ld_addr_c = {buf_q[gnt_idx_c].addr, {(AD_W-LA_W){1'b0}}};

    assign mcash_ch0_req_allowIn_o = allow_c[0];
    assign mcash_ch1_req_allowIn_o = allow_c[1];
    assign mcash_ch2_req_allowIn_o = allow_c[2];

    // Holding buffers: a grant and a new accept in the same cycle reload the slot
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned n = 0; n < NCH; n++) buf_q[n] <= '0;
            buf_vld_q <= '0;
        end else begin
            for (int unsigned n = 0; n < NCH; n++) begin
                if (accept_c[n]) buf_q[n] <= in_req_c[n];
            end
            buf_vld_q <= accept_c | (buf_vld_q & ~grant_c);
        end
    end

    // Output stage and round-robin pointer; payload frozen while stalled
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_vld_q  <= 1'b0;
            out_ch_q   <= '0;
            out_op_q   <= '0;
            out_addr_q <= '0;
            out_set_q  <= '0;
            rr_q       <= CH_W'(RR_INIT);
        end else if (out_load_c) begin
            out_vld_q <= gnt_vld_c;
            if (gnt_vld_c) begin
                out_ch_q   <= gnt_idx_c;
                out_op_q   <= buf_q[gnt_idx_c].op;
                out_addr_q <= ld_addr_c;
                out_set_q  <= ld_addr_c[SET_LSB +: SET_W];
                rr_q       <= (gnt_idx_c == CH_W'(NCH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
            end
        end
    end

    assign xbar_htu_valid_o  = out_vld_q;
    assign xbar_htu_ch_id_o  = out_ch_q;
    assign xbar_htu_opcode_o = out_op_q;
    assign xbar_htu_addr_o   = out_addr_q;
    assign xbar_htu_set_o    = out_set_q;

`ifdef XBAR_ARB_PERF_EN
    logic [CNT_W-1:0] gcnt_q [NCH];
    logic [CNT_W-1:0] scnt_q;

    // Saturating grant and stall counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned n = 0; n < NCH; n++) gcnt_q[n] <= '0;
            scnt_q <= '0;
        end else begin
            for (int unsigned n = 0; n < NCH; n++) begin
                if (grant_c[n] && (gcnt_q[n] != '1)) gcnt_q[n] <= gcnt_q[n] + CNT_W'(1);
            end
            if (out_vld_q && !xbar_htu_ready_i && (scnt_q != '1)) scnt_q <= scnt_q + CNT_W'(1);
        end
    end

    assign perf_grant_cnt_ch0_o = gcnt_q[0];
    assign perf_grant_cnt_ch1_o = gcnt_q[1];
    assign perf_grant_cnt_ch2_o = gcnt_q[2];
    assign perf_stall_cnt_o     = scnt_q;
`endif

endmodule

// File: tb/tb_cross_bar_req_arb.sv
// Testbench for cross_bar_req_arb: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the arbiter rules.
module tb_cross_bar_req_arb;

    localparam int SET_LSB = 4;
    localparam int SET_W   = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  v;
    logic [2:0]  op [3];
    logic [27:0] ad [3];
    logic        ready;

    logic        allow0, allow1, allow2;
    logic        valid;
    logic [1:0]  ch_id;
    logic [1:0]  opcode;
    logic [31:0] addr;
    logic [2:0]  set;
    wire  [2:0]  dut_allow = {allow2, allow1, allow0};
`ifdef XBAR_ARB_PERF_EN
    logic [15:0] pg0, pg1, pg2, pst;
`endif

    always #5 clk_i = ~clk_i;

    cross_bar_req_arb dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .mcash_ch0_req_valid_i   (v[0]),
        .mcash_ch0_req_allowIn_o (allow0),
        .mcash_ch0_req_op_i      (op[0]),
        .mcash_ch0_req_addr_i    (ad[0]),
        .mcash_ch1_req_valid_i   (v[1]),
        .mcash_ch1_req_allowIn_o (allow1),
        .mcash_ch1_req_op_i      (op[1]),
        .mcash_ch1_req_addr_i    (ad[1]),
        .mcash_ch2_req_valid_i   (v[2]),
        .mcash_ch2_req_allowIn_o (allow2),
        .mcash_ch2_req_op_i      (op[2]),
        .mcash_ch2_req_addr_i    (ad[2]),
        .xbar_htu_valid_o        (valid),
        .xbar_htu_ready_i        (ready),
        .xbar_htu_ch_id_o        (ch_id),
        .xbar_htu_opcode_o       (opcode),
        .xbar_htu_addr_o         (addr),
        .xbar_htu_set_o          (set)
`ifdef XBAR_ARB_PERF_EN
        ,
        .perf_grant_cnt_ch0_o    (pg0),
        .perf_grant_cnt_ch1_o    (pg1),
        .perf_grant_cnt_ch2_o    (pg2),
        .perf_stall_cnt_o        (pst)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_bv  [3];
    logic [2:0]  m_bop [3];
    logic [27:0] m_bad [3];
    int          m_rr;
    bit          m_ov;
    int          m_och;
    logic [1:0]  m_oop;
    logic [27:0] m_ola;
    bit          acc_last [3];
    int          m_gcnt [3];
    int          m_scnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_grant();
        int idx;
        if (m_ov && !ready) return -1;
        for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (m_bv[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_bv[n] = 0; m_bop[n] = '0; m_bad[n] = '0; acc_last[n] = 0; m_gcnt[n] = 0;
        end
        m_rr = 0; m_ov = 0; m_och = 0; m_oop = '0; m_ola = '0; m_scnt = 0;
    endtask

    // Compare DUT against the model for the current cycle, then advance the model by one edge
    task automatic model_step();
        int g;
        logic [31:0] full;
        bit acc;
        g = m_grant();
        for (int n = 0; n < 3; n++)
            check_eq($sformatf("allow%0d", n), 32'(dut_allow[n]), 32'(!m_bv[n] || g == n));
        check_eq("out_valid", 32'(valid), 32'(m_ov));
        if (m_ov) begin
            full = {m_ola, 4'h0};
            check_eq("out_ch", 32'(ch_id), 32'(m_och));
            check_eq("out_op", 32'(opcode), 32'(m_oop));
            check_eq("out_addr", addr, full);
            check_eq("out_set", 32'(set), (full >> SET_LSB) & ((32'd1 << SET_W) - 1));
        end
`ifdef XBAR_ARB_PERF_EN
        check_eq("perf_g0", 32'(pg0), 32'(m_gcnt[0]));
        check_eq("perf_g1", 32'(pg1), 32'(m_gcnt[1]));
        check_eq("perf_g2", 32'(pg2), 32'(m_gcnt[2]));
        check_eq("perf_st", 32'(pst), 32'(m_scnt));
`endif
        if (m_ov && !ready && m_scnt < 65535) m_scnt++;
        if (g >= 0) begin
            m_ov = 1; m_och = g; m_oop = m_bop[g][1:0]; m_ola = m_bad[g];
            m_rr = (g + 1) % 3;
            if (m_gcnt[g] < 65535) m_gcnt[g]++;
        end else if (!m_ov || ready) begin
            m_ov = 0;
        end
        for (int n = 0; n < 3; n++) begin
            acc = v[n] && (!m_bv[n] || g == n);
            acc_last[n] = acc;
            if (acc) begin
                m_bv[n] = 1; m_bop[n] = op[n]; m_bad[n] = ad[n];
            end else if (g == n) begin
                m_bv[n] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a fresh request on every channel whose previous one was just accepted
    task automatic refresh();
        for (int n = 0; n < 3; n++) begin
            if (acc_last[n]) begin
                op[n] = 3'($urandom);
                ad[n] = 28'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        v = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    logic [35:0] held;

    initial begin
        v = '0; ready = 1'b0;
        for (int n = 0; n < 3; n++) begin op[n] = '0; ad[n] = '0; end
        do_reset();

        // Idle after reset
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_allow", 32'(dut_allow), 32'd7);
        check_eq("rst_addr", addr, 32'd0);
        ready = 1'b1;
        repeat (5) tick();
        check_eq("idle_valid", 32'(valid), 32'd0);

        // Single ch1 request: visible two cycles after acceptance
        v[1] = 1'b1; op[1] = 3'b101; ad[1] = 28'h00000A5;
        tick();
        v[1] = 1'b0;
        tick();
        check_eq("single_valid", 32'(valid), 32'd1);
        check_eq("single_ch", 32'(ch_id), 32'd1);
        check_eq("single_op", 32'(opcode), 32'd1);
        check_eq("single_addr", addr, 32'h00000A50);
        check_eq("single_set", 32'(set), 32'd5);
        repeat (2) tick();

        // All channels busy: strictly cyclic grants at full rate
        do_reset();
        ready = 1'b1; v = 3'b111;
        for (int n = 0; n < 3; n++) begin op[n] = 3'(n); ad[n] = 28'(32'h100 + n); end
        for (int c = 1; c <= 9; c++) begin
            tick();
            refresh();
            if (c >= 2) check_eq("rr_seq", 32'(ch_id), 32'((c - 2) % 3));
        end

        // Stall with all channels valid: payload frozen, backpressure everywhere
        ready = 1'b0;
        held = {ch_id, opcode, addr};
        for (int c = 0; c < 5; c++) begin
            tick();
            refresh();
            check_eq("stall_stable", 32'({ch_id, opcode, addr} == held), 32'd1);
        end
        check_eq("stall_allow", 32'(dut_allow), 32'd0);
        ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int n = 0; n < 3; n++) if (acc_last[n]) v[n] = 1'b0;
        end
        check_eq("drain_valid", 32'(valid), 32'd0);

        // Grant to ch2 coinciding with a new ch2 request; pointer must wrap to 0
        do_reset();
        ready = 1'b1;
        v = 3'b100; op[2] = 3'b010; ad[2] = 28'h1234567;
        tick();
        v[2] = 1'b1; op[2] = 3'b011; ad[2] = 28'h7654321;
        v[1] = 1'b1; op[1] = 3'b001; ad[1] = 28'h0000111;
        check_eq("wrap_allow2", 32'(allow2), 32'd1);
        tick();
        v = '0;
        check_eq("wrap_ch2", 32'(ch_id), 32'd2);
        check_eq("wrap_addr_a", addr, 32'h12345670);
        tick();
        check_eq("wrap_ch1", 32'(ch_id), 32'd1);
        tick();
        check_eq("wrap_ch2b", 32'(ch_id), 32'd2);
        check_eq("wrap_addr_b", addr, 32'h76543210);
        check_eq("wrap_op_b", 32'(opcode), 32'd3);
        tick();

        // Asynchronous reset in the middle of a stalled transfer
        ready = 1'b0; v = 3'b111;
        for (int c = 0; c < 4; c++) begin
            tick();
            refresh();
        end
        check_eq("mid_valid_pre", 32'(valid), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("mid_valid_rst", 32'(valid), 32'd0);
        check_eq("mid_allow_rst", 32'(dut_allow), 32'd7);
        model_reset();
        v = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        check_eq("mid_allow_rel", 32'(dut_allow), 32'd7);
        check_eq("mid_valid_rel", 32'(valid), 32'd0);
`ifdef XBAR_ARB_PERF_EN
        check_eq("mid_perf", 32'(pg0 | pg1 | pg2 | pst), 32'd0);
`endif
        tick();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 3; n++) begin
                if (!v[n] || acc_last[n]) begin
                    v[n]  = ($urandom_range(0, 99) < 60);
                    op[n] = 3'($urandom);
                    ad[n] = 28'($urandom);
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
